// File: rtl/mbus_fabric_pkg.sv
// Shared types and helpers for the mbus_fabric interconnect.
package mbus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int ERRCNT_W = 8;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    if (v == {ERRCNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + ERRCNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/mbus_fabric_if.sv
// Memory-bus signals between the CPU master, the fabric and the slave channels.
interface mbus_fabric_if #(
  parameter int WIDTH = 32,
  parameter int NSLV  = 8
);
  logic                  m_req;
  logic [WIDTH-1:0]      m_addr;
  logic                  m_wen;
  logic [WIDTH-1:0]      m_wdata;
  logic                  m_rdy;
  logic [WIDTH-1:0]      m_rdata;
  logic                  m_err;
  logic [NSLV-1:0]       s_cs;
  logic                  s_wen;
  logic [WIDTH-1:0]      s_addr;
  logic [WIDTH-1:0]      s_wdata;
  logic [NSLV*WIDTH-1:0] s_rdata;
  logic [NSLV-1:0]       s_rdy;

  // Fabric side: answers the CPU and drives the slave channels.
  modport slave (
    input  m_req, m_addr, m_wen, m_wdata, s_rdata, s_rdy,
    output m_rdy, m_rdata, m_err, s_cs, s_wen, s_addr, s_wdata
  );

  // Environment side: the CPU together with the peripherals.
  modport master (
    output m_req, m_addr, m_wen, m_wdata, s_rdata, s_rdy,
    input  m_rdy, m_rdata, m_err, s_cs, s_wen, s_addr, s_wdata
  );
endinterface

// File: rtl/mbus_fabric_page_decode.sv
// Combinational page decoder: maps addr[15:12] to the lowest-indexed claiming slave.
module mbus_page_decode #(
  parameter int                 WIDTH    = 32,
  parameter int                 NSLV     = 8,
  parameter int                 SEL_W    = 3,
  parameter logic [NSLV*16-1:0] PAGE_MAP = '0
) (
  input  logic [WIDTH-1:12] addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel
);

  // Scan from the top so the lowest claiming index is written last and wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    if (addr[WIDTH-1:16] == '0) begin
      for (int s = NSLV - 1; s >= 0; s--) begin
        if (PAGE_MAP[16*s + int'(addr[15:12])]) begin
          hit = 1'b1;
          sel = SEL_W'(s);
        end
      end
    end else begin
      hit = 1'b0;
      sel = '0;
    end
  end

endmodule

// File: rtl/mbus_fabric.sv
// CPU-to-peripheral memory-bus fabric: page decode, wait-state handshake,
// timeout watchdog, unmapped-address errors and error logging.
module mbus_fabric
  import mbus_fabric_pkg::*;
#(
  parameter int                 WIDTH    = 32,
  parameter int                 NSLV     = 8,
  parameter logic [NSLV*16-1:0] PAGE_MAP = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  mbus_fabric_if.slave        bus,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [WIDTH-1:0]    err_addr
);

  localparam int         SEL_W   = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WIDTH-1:0]    err_addr_q, err_addr_d, log_addr_s;
  logic                wen_q, wen_d, swen_q, swen_d, rdy_q, rdy_d;
  logic                err_q, err_d, busy_q, busy_d;
  logic [SEL_W-1:0]    sel_q, sel_d, dec_sel_s;
  logic [NSLV-1:0]     cs_q, cs_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                dec_hit_s, log_err_s;

  mbus_page_decode #(
    .WIDTH    (WIDTH),
    .NSLV     (NSLV),
    .SEL_W    (SEL_W),
    .PAGE_MAP (PAGE_MAP)
  ) u_decode (
    .addr (bus.m_addr[WIDTH-1:12]),
    .hit  (dec_hit_s),
    .sel  (dec_sel_s)
  );

  // Next-state logic; every output flop is loaded with its value for the next state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wen_d      = wen_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cs_d       = cs_q;
    swen_d     = swen_q;
    busy_d     = busy_q;
    rdy_d      = 1'b0;
    log_err_s  = 1'b0;
    log_addr_s = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          addr_d  = bus.m_addr;
          wen_d   = bus.m_wen;
          wdata_d = bus.m_wdata;
          sel_d   = dec_sel_s;
          busy_d  = 1'b1;
          if (dec_hit_s) begin
            state_d = ACCESS;
            cnt_d   = 8'd0;
            cs_d    = NSLV'(1'b1) << dec_sel_s;
            swen_d  = bus.m_wen;
          end else begin
            state_d    = RESP;
            err_d      = 1'b1;
            rdata_d    = '0;
            rdy_d      = 1'b1;
            log_err_s  = 1'b1;
            log_addr_s = bus.m_addr;
          end
        end else begin
          busy_d = 1'b0;
          cs_d   = '0;
          swen_d = 1'b0;
        end
      end
      ACCESS: begin
        if (bus.s_rdy[sel_q]) begin
          state_d = RESP;
          rdata_d = wen_q ? '0 : bus.s_rdata[WIDTH*sel_q +: WIDTH];
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          cs_d    = '0;
          swen_d  = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d    = RESP;
          rdata_d    = '0;
          err_d      = 1'b1;
          rdy_d      = 1'b1;
          cs_d       = '0;
          swen_d     = 1'b0;
          log_err_s  = 1'b1;
          log_addr_s = addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cs_d    = '0;
        swen_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cs_d    = '0;
        swen_d  = 1'b0;
      end
    endcase
    err_cnt_d  = log_err_s ? sat_inc(err_cnt_q) : err_cnt_q;
    err_addr_d = log_err_s ? log_addr_s : err_addr_q;
  end

  // State and registered outputs; reset drops the slave select without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= 8'd0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cs_q       <= '0;
      swen_q     <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cs_q       <= cs_d;
      swen_q     <= swen_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.m_rdy   = rdy_q;
  assign bus.m_rdata = rdata_q;
  assign bus.m_err   = err_q;
  assign bus.s_cs    = cs_q;
  assign bus.s_wen   = swen_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign busy        = busy_q;
  assign err_count   = err_cnt_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_mbus_fabric.sv
// Randomized bench for mbus_fabric against a transaction-level reference model.
module tb_mbus_fabric;

  localparam int WIDTH   = 32;
  localparam int NSLV    = 8;
  localparam int TIMEOUT = 4;
  // s0: pages 0-3, s1: 4-7 and F, s2: C, s3: 8,9,F, s4: 8 (shadowed by s3)
  localparam logic [NSLV*16-1:0] PAGE_MAP = {16'h0000, 16'h0000, 16'h0000, 16'h0100,
                                             16'h8300, 16'h1000, 16'h80F0, 16'h000F};

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [7:0]  err_count;
  logic [31:0] err_addr;

  mbus_fabric_if #(.WIDTH(WIDTH), .NSLV(NSLV)) bus ();

  mbus_fabric #(
    .WIDTH    (WIDTH),
    .NSLV     (NSLV),
    .PAGE_MAP (PAGE_MAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          exp_on = 1'b0;
  logic        exp_rdy, exp_err, exp_swen, exp_busy, exp_chk_s;
  logic [31:0] exp_rdata, exp_saddr, exp_swdata;
  logic [7:0]  exp_cs;
  int          m_cnt;
  logic [31:0] m_eaddr;

  int          cs_cycles = 0;
  logic [7:0]  last_cs = 8'h00;
  int          last_rdy_cyc = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  int          start_cyc, cs_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Single compare point: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (bus.s_cs != 8'h00) begin
      cs_cycles++;
      last_cs = bus.s_cs;
    end
    if (bus.m_rdy === 1'b1) begin
      last_rdy_cyc = cyc;
      last_err     = bus.m_err;
      last_rdata   = bus.m_rdata;
    end
    if (exp_on) begin
      chk("m_rdy", 32'(bus.m_rdy), 32'(exp_rdy));
      if (exp_rdy) begin
        chk("m_err", 32'(bus.m_err), 32'(exp_err));
        chk("m_rdata", bus.m_rdata, exp_rdata);
      end
      chk("s_cs", 32'(bus.s_cs), 32'(exp_cs));
      chk("s_wen", 32'(bus.s_wen), 32'(exp_swen));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_chk_s) begin
        chk("s_addr", bus.s_addr, exp_saddr);
        chk("s_wdata", bus.s_wdata, exp_swdata);
      end
      chk("err_count", 32'(err_count), 32'(m_cnt));
      chk("err_addr", err_addr, m_eaddr);
    end
  end

  function automatic void model_decode(input logic [31:0] a, output bit hit, output int sel);
    hit = 1'b0;
    sel = 0;
    if (a[31:16] == 16'h0) begin
      for (int s = 0; s < NSLV; s++) begin
        if (!hit && PAGE_MAP[16*s + int'(a[15:12])]) begin
          hit = 1'b1;
          sel = s;
        end
      end
    end
  endfunction

  task automatic noise(input bit selv, input int sel, input bit rdyv, input logic [31:0] rd);
    for (int s = 0; s < NSLV; s++) begin
      bus.s_rdy[s] = 1'($urandom);
      bus.s_rdata[32*s +: 32] = $urandom;
    end
    if (selv) begin
      bus.s_rdy[sel] = rdyv;
      bus.s_rdata[32*sel +: 32] = rd;
    end
  endtask

  task automatic set_idle();
    exp_rdy   = 1'b0;
    exp_cs    = 8'h00;
    exp_swen  = 1'b0;
    exp_busy  = 1'b0;
    exp_chk_s = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.m_req = 1'b0;
    noise(1'b0, 0, 1'b0, 32'h0);
    set_idle();
  endtask

  // One transaction; the selected slave becomes ready after w ACCESS cycles.
  task automatic txn(input logic [31:0] a, input bit wen, input logic [31:0] d,
                     input int w, input logic [31:0] rd, input bit hold);
    bit hit;
    int sel;
    int r;
    bit err;
    logic [31:0] exp_rd;
    model_decode(a, hit, sel);
    if (!hit) begin
      r = 1; err = 1'b1;
    end else if (w < TIMEOUT) begin
      r = w + 2; err = 1'b0;
    end else begin
      r = TIMEOUT + 1; err = 1'b1;
    end
    exp_rd = (hit && !err && !wen) ? rd : 32'h0;
    @(posedge clk); #1;
    start_cyc   = cyc;
    cs_base     = cs_cycles;
    bus.m_req   = 1'b1;
    bus.m_addr  = a;
    bus.m_wen   = wen;
    bus.m_wdata = d;
    noise(1'b0, 0, 1'b0, 32'h0);
    set_idle();
    for (int n = 1; n <= r; n++) begin
      @(posedge clk); #1;
      exp_saddr  = a;
      exp_swdata = d;
      exp_chk_s  = 1'b1;
      exp_busy   = 1'b1;
      if (n < r) begin
        exp_rdy  = 1'b0;
        exp_cs   = 8'h01 << sel;
        exp_swen = wen;
        noise(1'b1, sel, (n - 1) >= w, rd);
      end else begin
        exp_rdy   = 1'b1;
        exp_err   = err;
        exp_rdata = exp_rd;
        exp_cs    = 8'h00;
        exp_swen  = 1'b0;
        if (err) begin
          if (m_cnt < 255) m_cnt++;
          m_eaddr = a;
        end
        noise(1'b0, 0, 1'b0, 32'h0);
        if (!hold) bus.m_req = 1'b0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    reset       = 1'b1;
    bus.m_req   = 1'b0;
    bus.m_addr  = 32'h0;
    bus.m_wen   = 1'b0;
    bus.m_wdata = 32'h0;
    noise(1'b0, 0, 1'b0, 32'h0);
    set_idle();
    exp_chk_s  = 1'b1;
    exp_saddr  = 32'h0;
    exp_swdata = 32'h0;
    m_cnt      = 0;
    m_eaddr    = 32'h0;
    exp_on     = 1'b1;
    #2;
    chk("rst m_rdata", bus.m_rdata, 32'h0);
    chk("rst m_err", 32'(bus.m_err), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    set_idle();

    txn(32'h0000_0123, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    settle();
    chk("zw latency", 32'(last_rdy_cyc - start_cyc), 32'd2);
    chk("zw cs cycles", 32'(cs_cycles - cs_base), 32'd1);
    chk("zw cs value", 32'(last_cs), 32'h01);

    txn(32'h0000_C000, 1'b0, 32'h0, 3, 32'h0000_55AA, 1'b0);
    settle();
    chk("ws latency", 32'(last_rdy_cyc - start_cyc), 32'd5);
    chk("ws rdata", last_rdata, 32'h0000_55AA);
    chk("ws cs value", 32'(last_cs), 32'h04);

    txn(32'h0001_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    settle();
    chk("um latency", 32'(last_rdy_cyc - start_cyc), 32'd1);
    chk("um err", 32'(last_err), 32'h1);
    chk("um cs cycles", 32'(cs_cycles - cs_base), 32'd0);
    chk("um err_count", 32'(err_count), 32'd1);
    chk("um err_addr", err_addr, 32'h0001_0000);

    txn(32'h0000_4000, 1'b0, 32'h0, 99, 32'h0, 1'b0);
    settle();
    chk("to cs cycles", 32'(cs_cycles - cs_base), 32'd4);
    chk("to latency", 32'(last_rdy_cyc - start_cyc), 32'd5);
    chk("to err", 32'(last_err), 32'h1);
    chk("to err_count", 32'(err_count), 32'd2);

    txn(32'h0000_F000, 1'b0, 32'h0, 0, 32'h1111_2222, 1'b1);
    settle();
    chk("prio F cs", 32'(last_cs), 32'h02);
    txn(32'h0000_8004, 1'b0, 32'h0, 1, 32'h3333_4444, 1'b0);
    settle();
    chk("prio 8 cs", 32'(last_cs), 32'h08);

    // Reset while slave 2 is stretching the access.
    @(posedge clk); #1;
    bus.m_req  = 1'b1;
    bus.m_addr = 32'h0000_C010;
    bus.m_wen  = 1'b0;
    noise(1'b1, 2, 1'b0, 32'h0);
    set_idle();
    for (int n = 1; n <= 2; n++) begin
      @(posedge clk); #1;
      exp_rdy = 1'b0; exp_cs = 8'h04; exp_swen = 1'b0; exp_busy = 1'b1;
      exp_chk_s = 1'b1; exp_saddr = 32'h0000_C010; exp_swdata = bus.m_wdata;
      noise(1'b1, 2, 1'b0, 32'h0);
    end
    #6;
    exp_on = 1'b0;
    reset  = 1'b1;
    bus.m_req = 1'b0;
    #1;
    chk("mid-rst s_cs", 32'(bus.s_cs), 32'h0);
    chk("mid-rst busy", 32'(busy), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("mid-rst m_rdy", 32'(bus.m_rdy), 32'h0);
    end
    @(posedge clk); #1;
    reset   = 1'b0;
    m_cnt   = 0;
    m_eaddr = 32'h0;
    set_idle();
    exp_on  = 1'b1;
    txn(32'h0000_0010, 1'b0, 32'h0, 1, 32'h0000_1234, 1'b0);
    settle();
    chk("post-rst rdata", last_rdata, 32'h0000_1234);
    chk("post-rst err_count", 32'(err_count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0001_0000;
      else a = {16'h0000, 16'($urandom)};
      txn(a, 1'($urandom), $urandom, $urandom_range(0, TIMEOUT + 1), $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    for (int i = 0; i < 300; i++) begin
      txn(32'h00A0_0000 + 32'(i), 1'b0, 32'h0, 0, 32'h0, 1'($urandom));
    end
    txn(32'h00A0_1230, 1'b1, 32'h0, 0, 32'h0, 1'b0);
    settle();
    chk("sat err_count", 32'(err_count), 32'd255);
    chk("sat err_addr", err_addr, 32'h00A0_1230);

    idle_cycle();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbus_fabric.md
Name: mbus_fabric

Overview:
- Parametrised memory-bus interconnect between the single CPU master and up to NSLV slaves. It replaces the fixed page decoder and combinational read mux.
- Adds a per-transaction ready handshake, variable slave wait states, a timeout watchdog, unmapped-address error responses and error logging.
- Sits between cpu mbus_* ports and the memory, timer, gpio and simif peripherals in the computer top.

Parameters:
- WIDTH, 32, data and address width.
- NSLV, 8, number of slave channels (1..16).
- PAGE_MAP, 0 (NSLV*16 bits), field s (bits 16s+15..16s) is a 16-bit mask; bit p set means slave s claims page addr[15:12]==p.
- TIMEOUT, 15, maximum ACCESS cycles waiting for s_rdy before an error completion (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  1  master request; held with addr/wen/wdata stable until m_rdy.
- m_addr  in  WIDTH  master address.
- m_wen  in  1  1=write, 0=read.
- m_wdata  in  WIDTH  master write data.
- m_rdy  out  1  one-cycle completion pulse.
- m_rdata  out  WIDTH  read data, valid while m_rdy=1.
- m_err  out  1  error completion, valid while m_rdy=1.
- s_cs  out  NSLV  one-hot slave select.
- s_wen  out  1  write strobe to slaves.
- s_addr  out  WIDTH  registered transaction address.
- s_wdata  out  WIDTH  registered write data.
- s_rdata  in  NSLV*WIDTH  slave read data, slave s at bits WIDTH*s+WIDTH-1..WIDTH*s.
- s_rdy  in  NSLV  slave ready; tie high for zero-wait slaves.
- busy  out  1  state != IDLE.
- err_count  out  8  saturating count of error completions.
- err_addr  out  WIDTH  address of the most recent error completion.

Behaviour:
- Reset (asynchronous): state=IDLE; s_cs, s_wen, m_rdy, m_err, busy = 0; m_rdata, s_addr, s_wdata, err_addr = 0; err_count=0; wait counter=0. Reset mid-transaction drops s_cs immediately and issues no response.
- Decode is combinational on m_addr. Hit requires m_addr[31:16]==0 and at least one slave with PAGE_MAP bit m_addr[15:12] set. When several slaves claim the page, the lowest index wins.
- IDLE: when m_req=1, register addr, wen, wdata and the selected index. A hit goes to ACCESS with wait counter=0; a miss goes to RESP with err=1 and data=0.
- ACCESS: s_cs[sel]=1; s_wen=registered wen.
  - If s_rdy[sel]=1: capture s_rdata[sel] (0 on write), err=0, go to RESP.
  - Else if counter==TIMEOUT-1: err=1, data=0, go to RESP.
  - Else increment the counter.
- RESP: m_rdy=1, m_rdata and m_err driven from registers, s_cs=0. Always return to IDLE. m_req is ignored during RESP. A request still high in the following IDLE cycle starts a new transaction, so back-to-back is allowed.
- Latency: m_req sampled at edge k gives ACCESS in cycle k+1. With zero wait states, m_rdy is high in cycle k+2. Each wait state adds one cycle. A timeout gives m_rdy in cycle k+1+TIMEOUT.
- Zero-wait write: the slave samples s_wen/s_wdata/s_addr at the edge ending the first ACCESS cycle.
- Error logging: on entering RESP with err=1, err_addr is loaded with the address and err_count increments, holding at 255.
- s_rdy or s_rdata from non-selected slaves are ignored.
- s_wen is never high outside ACCESS.

Decomposition:
- Shared package/defs: state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2; ERRCNT_W=8.
- Sub-module mbus_page_decode (combinational): inputs addr and PAGE_MAP; outputs hit and sel index (priority encoder).
- The FSM, registers and read mux live in mbus_fabric.

Test Plan:
- Zero-wait write: PAGE_MAP slave0=16'h000F, s_rdy=all 1; write 0x0000_0123 data 0xDEADBEEF → s_cs=8'h01 and s_wen=1 for exactly one cycle; m_rdy 2 cycles after request; m_err=0.
- Wait-state read: slave2 claims page 0xC; s_rdy[2] rises after 3 ACCESS cycles with s_rdata[2]=0x55AA → m_rdy 5 cycles after request; m_rdata=0x55AA.
- Unmapped: read 0x0001_0000 → m_rdy next cycle; m_err=1; m_rdata=0; no s_cs pulse; err_count=1; err_addr=0x0001_0000.
- Timeout: TIMEOUT=4, slave never ready → s_cs high for 4 cycles, then m_rdy with m_err=1; err_count increments. With 300 errors, err_count holds at 255.
- Priority overlap: slaves 1 and 3 both claim page 0xF; access 0xF000 → only s_cs[1] is asserted.
- Reset mid-ACCESS: assert reset during wait state → s_cs=0 and busy=0 immediately; no m_rdy. After release, a new request completes normally.
